xgmii_frame_gen: RTL and testbench
==================================

Name: xgmii_frame_gen

Overview:
- Synthetic Ethernet frame source driving the 64-bit XGMII TX interface (xgmii_txd/xgmii_txc) of a 10GBASE-R PCS/PMA channel, in place of the RX-to-TX loopback.
- Emits start/preamble/SFD, a deterministic byte-pattern payload of programmable length, a terminate character in the correct lane, and a minimum inter-frame gap of idles.
- Counts transmitted frames for VIO probing.

Parameters:
- LEN_WIDTH, 14, width of frame_len; payload length in bytes.
- MIN_LEN, 8, minimum payload bytes; shorter requests are clamped up.
- MAX_LEN, 9600, maximum payload bytes; longer requests are clamped down.
- IFG_WORDS, 2, minimum all-idle words between a terminate word and the next start word.
- CNT_WIDTH, 32, width of frame_cnt.

Ports:
- clk  in  1  core clock (coreclk domain, 156.25 MHz).
- rst  in  1  reset, asynchronous, active-high.
- enable  in  1  level; while high, frames are generated back-to-back, separated by the IFG.
- frame_len  in  LEN_WIDTH  payload bytes after SFD; sampled at frame start.
- xgmii_txd  out  64  XGMII TX data; lane n = bits [8n+7:8n]; lane 0 is first on the wire.
- xgmii_txc  out  8  XGMII TX control; bit n flags lane n as a control character.
- busy  out  1  high from the start word through the last IFG word.
- frame_cnt  out  CNT_WIDTH  number of completed frames; wraps modulo 2^CNT_WIDTH.

Behaviour:
- Reset (async assert; released synchronously inside the block) forces the following, immediately and mid-frame included:
  - xgmii_txd = 64'h0707070707070707, xgmii_txc = 8'hFF
  - busy = 0, frame_cnt = 0, state = IDLE, gap counter = IFG_WORDS (gap already satisfied)
- All outputs are registered. Idle word = txd 64'h0707070707070707, txc 8'hFF.
- State machine:
  - IDLE: outputs the idle word. If enable = 1, latch L = clamp(frame_len, MIN_LEN, MAX_LEN), set payload byte index k = 0, and go to START. The start word appears on the cycle after enable is sampled.
  - START: txd = 64'hD5555555555555FB, txc = 8'h01 (lane 0 = /S/ 0xFB, lanes 1-6 = 0x55, lane 7 = SFD 0xD5).
    - Next state is DATA if floor(L/8) > 0, else TERM. Clamping guarantees floor(L/8) ≥ 1.
  - DATA: emits floor(L/8) full words, txc = 8'h00; payload byte k = (frame_cnt[7:0] + k) mod 256, with k incremented per byte.
    - After the last full word, go to TERM.
  - TERM: with r = L mod 8:
    - lanes 0..r-1 carry the remaining payload bytes;
    - lane r = 0xFD (/T/);
    - lanes r+1..7 = 0x07;
    - txc = ~((8'h01 << r) - 1).
    - When r = 0: txd = 64'h07070707070707FD, txc = 8'hFF.
    - frame_cnt increments in this cycle (registered value visible the following cycle). Load the gap counter with 0; go to GAP.
  - GAP: outputs the idle word and increments the gap counter. Once it reaches IFG_WORDS, go to IDLE if enable = 0; otherwise re-sample enable, L and k, and go straight to START. The start word follows exactly IFG_WORDS idle words.
    - IFG_WORDS = 0 is legal: START directly follows TERM.
- enable is ignored in START/DATA/TERM/GAP: deasserting mid-frame completes the frame plus its IFG.
- frame_len changes mid-frame have no effect until the next frame start.
- busy = 1 in START, DATA, TERM and GAP; 0 in IDLE.
- Payload byte index k is LEN_WIDTH wide; only its low 8 bits enter the pattern sum, which wraps modulo 256.
- No deficit-idle, no FCS insertion: the payload is raw. Start is always in lane 0.

Test Plan:
- Reset then enable=1, frame_len=8, IFG_WORDS=2 -> cycle after enable:
  - FB start word, txc 01;
  - data word 64'h0706050403020100, txc 00;
  - 64'h07070707070707FD, txc FF;
  - 2 idle words, then the next start; frame_cnt = 1; second frame data word 64'h0807060504030201.
- frame_len=13 -> start, data 64'h0706050403020100, then term 64'h0707FD0C0B0A0908 with txc 8'hE0.
- frame_len=3 -> clamped to 8, identical to scenario 1. frame_len=16383 -> clamped to 9600: 1200 data words, term txc FF.
- enable dropped on the second DATA cycle of a 64-byte frame -> all 8 data words, term and IFG still emitted, then idle with busy=0; frame_cnt incremented by exactly 1.
- rst asserted in mid-DATA -> txd/txc become the idle word and frame_cnt = 0 without waiting for a clock edge. After release with enable=1, the first start word appears one cycle after enable is sampled, with no gap wait.
- Long run of 300 frames of frame_len=8 -> the first data byte of frame n equals n mod 256 (frame 256 restarts at 0x00); frame_cnt = 300.

Source files
------------

// File: rtl/xgmii_frame_gen.sv
// -----------------------------------------------------------------------------
// xgmii_frame_gen
//
// Synthetic Ethernet frame source for the 64-bit XGMII TX interface of a
// 10GBASE-R PCS/PMA channel. Each frame is:
//   start word (/S/ + 6x preamble + SFD), floor(L/8) full payload words,
//   one terminate word carrying the L mod 8 leftover bytes and /T/,
//   then IFG_WORDS all-idle words.
// The payload is a raw incrementing byte pattern seeded by the low byte of
// the completed-frame counter. No FCS is appended and no deficit idle
// count is kept. The start character always sits in lane 0.
//
// Ports:
//   clk        core clock (coreclk domain)
//   rst        asynchronous, active-high reset; deassertion is synchronised
//              internally
//   enable     level; while high, frames run back-to-back separated by the IFG
//   frame_len  payload bytes after the SFD, clamped to [MIN_LEN, MAX_LEN] and
//              sampled at each frame start
//   xgmii_txd  TX data; lane n = bits [8n+7:8n], lane 0 first on the wire
//   xgmii_txc  TX control; bit n marks lane n as a control character
//   busy       high from the start word through the last IFG word
//   frame_cnt  completed frames, wraps modulo 2^CNT_WIDTH
// -----------------------------------------------------------------------------
module xgmii_frame_gen #(
  parameter int LEN_WIDTH = 14,
  parameter int MIN_LEN   = 8,
  parameter int MAX_LEN   = 9600,
  parameter int IFG_WORDS = 2,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [LEN_WIDTH-1:0] frame_len,
  output logic [63:0]          xgmii_txd,
  output logic [7:0]           xgmii_txc,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] frame_cnt
);

  // ---------------------------------------------------------------------------
  // Constants and types
  // ---------------------------------------------------------------------------
  localparam logic [63:0] IDLE_WORD  = {8{8'h07}};
  localparam logic [63:0] START_WORD = 64'hD5555555555555FB;
  localparam logic [7:0]  IDLE_CTRL  = 8'hFF;
  localparam logic [7:0]  START_CTRL = 8'h01;

  localparam int GAP_W = (IFG_WORDS < 1) ? 1 : $clog2(IFG_WORDS + 1);
  localparam logic [GAP_W-1:0]     IFG_Q = GAP_W'(IFG_WORDS);
  localparam logic [LEN_WIDTH-1:0] MIN_Q = LEN_WIDTH'(MIN_LEN);
  localparam logic [LEN_WIDTH-1:0] MAX_Q = LEN_WIDTH'(MAX_LEN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_TERM,
    S_GAP
  } state_t;

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  c;
  } xgmii_word_t;

  // ---------------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------------
  function automatic logic [LEN_WIDTH-1:0] clamp_len(input logic [LEN_WIDTH-1:0] len);
    if (len < MIN_Q)      return MIN_Q;
    else if (len > MAX_Q) return MAX_Q;
    else                  return len;
  endfunction

  // Eight consecutive pattern bytes starting at base, lane 0 first.
  function automatic xgmii_word_t data_word(input logic [7:0] base);
    xgmii_word_t w;
    w.c = 8'h00;
    w.d = '0;
    for (int j = 0; j < 8; j++) begin
      w.d[8*j +: 8] = base + 8'(j);
    end
    return w;
  endfunction

  // Lanes below r carry the leftover payload, lane r is /T/, the rest idle.
  function automatic xgmii_word_t term_word(input logic [7:0] base, input logic [2:0] r);
    xgmii_word_t w;
    w.d = '0;
    w.c = '0;
    for (int j = 0; j < 8; j++) begin
      if (j < int'(r)) begin
        w.d[8*j +: 8] = base + 8'(j);
        w.c[j]        = 1'b0;
      end else if (j == int'(r)) begin
        w.d[8*j +: 8] = 8'hFD;
        w.c[j]        = 1'b1;
      end else begin
        w.d[8*j +: 8] = 8'h07;
        w.c[j]        = 1'b1;
      end
    end
    return w;
  endfunction

  // ---------------------------------------------------------------------------
  // Reset synchroniser: assertion reaches all state immediately, release is
  // aligned to clk so the FSM never leaves reset on a partial edge.
  // ---------------------------------------------------------------------------
  logic [1:0] rst_pipe;
  logic       rst_int;

  // NOTE: sequential state is always updated with non-blocking assignments so
  // every flop samples the pre-edge value of every other flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rst_pipe <= 2'b11;
    else     rst_pipe <= {rst_pipe[0], 1'b0};
  end

  assign rst_int = rst_pipe[1];

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t               state, state_n;
  logic [LEN_WIDTH-1:0] len_q, len_n;    // clamped payload length of this frame
  logic [LEN_WIDTH-1:0] k_q, k_n;        // index of the next payload byte to emit
  logic [GAP_W-1:0]     gap_q, gap_n;    // idle words already emitted in GAP
  logic [CNT_WIDTH-1:0] cnt_n;
  xgmii_word_t          word_n;
  logic                 launch;
  logic [7:0]           base;
  logic [LEN_WIDTH:0]   k_plus8;

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic. The output registers are loaded with
  // the word belonging to the state being entered, so a word is on the bus
  // during exactly the cycle its state is current.
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_n = state;
    word_n  = '{d: IDLE_WORD, c: IDLE_CTRL};
    len_n   = len_q;
    k_n     = k_q;
    gap_n   = gap_q;
    cnt_n   = frame_cnt;
    launch  = 1'b0;

    base    = frame_cnt[7:0] + k_q[7:0];
    k_plus8 = {1'b0, k_q} + (LEN_WIDTH + 1)'(8);

    unique case (state)
      S_IDLE: launch = 1'b1;

      // k always advances in whole words, so the leftover count after the
      // last full word is simply the low three bits of the length.
      S_START, S_DATA: begin
        if (k_plus8 <= {1'b0, len_q}) begin
          state_n = S_DATA;
          word_n  = data_word(base);
          k_n     = k_plus8[LEN_WIDTH-1:0];
        end else begin
          state_n = S_TERM;
          word_n  = term_word(base, len_q[2:0]);
        end
      end

      S_TERM: begin
        cnt_n = frame_cnt + CNT_WIDTH'(1);
        if (IFG_WORDS == 0) begin
          launch = 1'b1;
        end else begin
          state_n = S_GAP;
          gap_n   = GAP_W'(1);
        end
      end

      S_GAP: begin
        if (gap_q >= IFG_Q) launch = 1'b1;
        else                gap_n  = gap_q + GAP_W'(1);
      end

      default: state_n = S_IDLE;
    endcase

    // Frame start decision, shared by IDLE and the end of the gap.
    if (launch) begin
      if (enable) begin
        state_n = S_START;
        word_n  = '{d: START_WORD, c: START_CTRL};
        len_n   = clamp_len(frame_len);
        k_n     = '0;
      end else begin
        state_n = S_IDLE;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst_int) begin
    if (rst_int) begin
      state     <= S_IDLE;
      len_q     <= MIN_Q;
      k_q       <= '0;
      gap_q     <= IFG_Q;
      frame_cnt <= '0;
      xgmii_txd <= IDLE_WORD;
      xgmii_txc <= IDLE_CTRL;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      len_q     <= len_n;
      k_q       <= k_n;
      gap_q     <= gap_n;
      frame_cnt <= cnt_n;
      xgmii_txd <= word_n.d;
      xgmii_txc <= word_n.c;
      busy      <= (state_n != S_IDLE);
    end
  end

endmodule

// File: tb/tb_xgmii_frame_gen.sv
// -----------------------------------------------------------------------------
// tb_xgmii_frame_gen
//
// Directed + randomized bench for xgmii_frame_gen. Expected words are built
// from a byte-level description of each frame (preamble, pattern payload, /T/,
// idle padding, IFG) and then cut into 8-byte XGMII words.
// -----------------------------------------------------------------------------
module tb_xgmii_frame_gen;

  localparam int LW  = 14;
  localparam int IFG = 2;
  localparam int CW  = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic [LW-1:0] frame_len = '0;
  logic [63:0]   xgmii_txd;
  logic [7:0]    xgmii_txc;
  logic          busy;
  logic [CW-1:0] frame_cnt;

  xgmii_frame_gen #(
    .LEN_WIDTH (LW),
    .MIN_LEN   (8),
    .MAX_LEN   (9600),
    .IFG_WORDS (IFG),
    .CNT_WIDTH (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .frame_len (frame_len),
    .xgmii_txd (xgmii_txd),
    .xgmii_txc (xgmii_txc),
    .busy      (busy),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int mcnt     = 0;   // model of frames completed since reset

  // Expected word stream
  logic [63:0] q_d[$];
  logic [7:0]  q_c[$];
  int          q_cnt[$];   // expected frame_cnt on start words, -1 elsewhere
  int          q_wi[$];    // word index within its frame
  bit          q_last[$];  // last word of a frame (incl. IFG)

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Build one frame from its byte-level definition and append it to the queue.
  task automatic add_frame(input int lraw, input int n);
    int          len;
    int          nw;
    logic [7:0]  b[$];
    bit          c[$];
    logic [63:0] d;
    logic [7:0]  cc;
    len = (lraw < 8) ? 8 : ((lraw > 9600) ? 9600 : lraw);
    b.push_back(8'hFB); c.push_back(1'b1);
    repeat (6) begin b.push_back(8'h55); c.push_back(1'b0); end
    b.push_back(8'hD5); c.push_back(1'b0);
    for (int i = 0; i < len; i++) begin
      b.push_back(8'((n + i) & 255)); c.push_back(1'b0);
    end
    b.push_back(8'hFD); c.push_back(1'b1);
    while ((b.size() % 8) != 0) begin b.push_back(8'h07); c.push_back(1'b1); end
    nw = b.size() / 8;
    for (int w = 0; w < nw; w++) begin
      for (int j = 0; j < 8; j++) begin
        d[8*j +: 8] = b[8*w + j];
        cc[j]       = c[8*w + j];
      end
      q_d.push_back(d);
      q_c.push_back(cc);
      q_cnt.push_back((w == 0) ? n : -1);
      q_wi.push_back(w);
      q_last.push_back((IFG == 0) && (w == nw - 1));
    end
    for (int g = 0; g < IFG; g++) begin
      q_d.push_back({8{8'h07}});
      q_c.push_back(8'hFF);
      q_cnt.push_back(-1);
      q_wi.push_back(nw + g);
      q_last.push_back(g == IFG - 1);
    end
  endtask

  // Run nfr back-to-back frames of length len and check every word, then the
  // return to idle. Called at a negedge with the DUT idle (or leaving reset).
  task automatic stream(input int len, input int nfr, input bit wait_start);
    int          fr;
    bit          found;
    bit          have_sample;
    logic [63:0] ed;
    logic [7:0]  ec;
    int          en;
    int          wi;
    bit          last;
    for (int f = 0; f < nfr; f++) add_frame(len, mcnt + f);
    frame_len   = LW'(len);
    enable      = 1'b1;
    fr          = 0;
    have_sample = 1'b0;
    if (wait_start) begin
      found = 1'b0;
      for (int t = 0; t < 8 && !found; t++) begin
        @(negedge clk);
        if (xgmii_txc === 8'h01) found = 1'b1;
      end
      check("start_after_reset_release", 64'(found), 64'(1));
      have_sample = 1'b1;
    end
    while (q_d.size() > 0) begin
      if (have_sample) have_sample = 1'b0;
      else             @(negedge clk);
      ed   = q_d.pop_front();
      ec   = q_c.pop_front();
      en   = q_cnt.pop_front();
      wi   = q_wi.pop_front();
      last = q_last.pop_front();
      check("txd", xgmii_txd, ed);
      check("txc", 64'(xgmii_txc), 64'(ec));
      check("busy", 64'(busy), 64'(1));
      if (en >= 0) check("frame_cnt_at_start", 64'(frame_cnt), 64'(en));
      // Mid-frame length changes must not leak into the current frame.
      if (wi == 1) frame_len = LW'($urandom_range(0, 16383));
      if (last) begin
        frame_len = LW'(len);
        fr++;
      end
      if (fr == nfr - 1 && wi == 2) enable = 1'b0;
    end
    mcnt += nfr;
    @(negedge clk);
    check("idle_txd", xgmii_txd, {8{8'h07}});
    check("idle_txc", 64'(xgmii_txc), 64'hFF);
    check("idle_busy", 64'(busy), 64'(0));
    check("frame_cnt_after", 64'(frame_cnt), 64'(mcnt));
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_txd", xgmii_txd, {8{8'h07}});
    check("rst_txc", 64'(xgmii_txc), 64'hFF);
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_frame_cnt", 64'(frame_cnt), 64'(0));
    rst = 1'b0;

    // Two back-to-back minimum frames, then various lengths and clamps
    stream(8, 2, 1'b1);
    stream(13, 1, 1'b0);
    stream(3, 1, 1'b0);
    stream(16383, 1, 1'b0);
    // enable drops on the second data word; frame and IFG still complete
    stream(64, 1, 1'b0);

    // Randomized lengths
    repeat (6) stream($urandom_range(0, 200), 1, 1'b0);
    stream($urandom_range(8, 100), 3, 1'b0);

    // Reset in the middle of a frame
    frame_len = LW'(64);
    enable    = 1'b1;
    @(negedge clk);
    check("pre_rst_start_txd", xgmii_txd, 64'hD5555555555555FB);
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_busy", 64'(busy), 64'(1));
    #2 rst = 1'b1;
    #1;
    check("async_rst_txd", xgmii_txd, {8{8'h07}});
    check("async_rst_txc", 64'(xgmii_txc), 64'hFF);
    check("async_rst_busy", 64'(busy), 64'(0));
    check("async_rst_frame_cnt", 64'(frame_cnt), 64'(0));
    @(negedge clk);
    rst  = 1'b0;
    mcnt = 0;
    stream(8, 1, 1'b1);

    // Long run: pattern seed wraps after 256 frames
    mcnt = 1;
    mcnt = mcnt - 1 + 1;
    stream(8, 300, 1'b0);
    check("frame_cnt_long_run", 64'(frame_cnt), 64'(301));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
